divide_iter: RTL and testbench
==============================

# divide_iter

Parametrised iterative signed fixed-point divider with ready/valid handshakes on both sides. Computes `(dividend << QUANTIZED_BITS) / divisor`, one quotient bit per cycle. Adds saturation, divide-by-zero and overflow flags, and a tag passthrough, so multiple callers can share one unit behind an arbiter in the ray/geometry datapath.

## Interface
- `DATA_WIDTH`, default 16: operand and result width, signed two's complement.
- `QUANTIZED_BITS`, default 8: fractional bits of the fixed-point format (Q = QUANTIZED_BITS); must be ≥0.
- `ID_WIDTH`, default 4: width of the opaque tag carried from input to output.
- `clock`  in  1: sole clock; all state updates on the rising edge.
- `reset`  in  1: asynchronous, active-low reset; asserting it (low) clears all state immediately.
- `valid_in`  in  1: operands valid.
- `ready_in`  out  1: block can accept; high only in IDLE.
- `dividend`  in  DATA_WIDTH: signed numerator, Q-format.
- `divisor`  in  DATA_WIDTH: signed denominator, Q-format.
- `id_in`  in  ID_WIDTH: tag, captured with the operands.
- `valid_out`  out  1: result valid; held until accepted.
- `ready_out`  in  1: downstream accepts the result.
- `quotient`  out  DATA_WIDTH: signed, saturated quotient, Q-format.
- `remainder`  out  DATA_WIDTH: signed remainder of the unsaturated division.
- `div_by_zero`  out  1: divisor was 0.
- `overflow`  out  1: true quotient exceeded the signed DATA_WIDTH range and was saturated.
- `id_out`  out  ID_WIDTH: tag of the current result.

## Operation
- States: IDLE, CALC, DONE.
  - Reset enters IDLE.
  - `ready_in` = (state == IDLE), driven combinationally from the state register.
- Accept: `valid_in && ready_in` at an edge.
  - Capture the operand signs, `id_in`, |dividend| and |divisor| as DATA_WIDTH-bit unsigned magnitudes (|−2^(W−1)| = 2^(W−1) is representable).
  - Numerator N = |dividend| << Q, width W+Q.
  - Load the iteration counter with W+Q.
  - If divisor == 0, go to DONE; otherwise go to CALC.
- CALC: one restoring-division step per edge, MSB of N first.
  - Shift the partial remainder left and bring in the next N bit.
  - If partial remainder ≥ |divisor|, subtract and set the quotient bit to 1.
  - Partial remainder is DATA_WIDTH+1 bits; the quotient register is W+Q bits.
  - After W+Q steps, one further edge performs sign correction and saturation, then enters DONE.
- Result rules, W = DATA_WIDTH:
  - Quotient sign = sign(dividend) XOR sign(divisor); truncation is toward zero.
  - If the signed quotient is greater than 2^(W−1)−1, output 2^(W−1)−1 and set `overflow`. If it is less than −2^(W−1), output −2^(W−1) and set `overflow`.
  - Remainder has the sign of the dividend, |remainder| < |divisor|, and is always the unsaturated remainder.
- Divide-by-zero:
  - quotient = 2^(W−1)−1 if dividend ≥ 0, else −2^(W−1).
  - remainder = 0, `div_by_zero` = 1, `overflow` = 0.
- DONE:
  - Outputs are registered and stable while `valid_out` = 1.
  - On `valid_out && ready_out`, go to IDLE.
  - No new operation is accepted in the same cycle.
- Reset (low) mid-operation: the operation is abandoned with no output. The state goes to IDLE, all registers clear and `valid_out` drops immediately.

## Timing
- Reset values:
  - `valid_out`, `quotient`, `remainder`, `div_by_zero`, `overflow`, `id_out` = 0.
  - State = IDLE, so `ready_in` = 1 once reset is deasserted. Upstream must not present operands while reset is asserted.
- Latency, normal divide:
  - Accept edge = edge 0.
  - `valid_out` rises after edge W+Q+1 (25 cycles at the defaults).
- Latency, divide-by-zero: `valid_out` rises after edge 1.
- Throughput: at most one operation per W+Q+3 cycles with `ready_out` held high.
- `ready_out` low stalls indefinitely in DONE; outputs must not change while stalled.
- Input signals are ignored outside IDLE; changes to `dividend`/`divisor` after accept have no effect.

## Test plan
1. Defaults: dividend=194, divisor=10, id=3 → after 25 edges `valid_out`=1, quotient=4966, remainder=4, flags 0, id_out=3.
2. Signs: −194/10 → quotient −4966, remainder −4. 194/−10 → quotient −4966, remainder 4. −32768/−32768 → quotient 256, remainder 0.
3. Saturation: 32767/1 → quotient 32767, overflow=1, remainder 0. −32768/1 → quotient −32768, overflow=1.
4. Divide-by-zero: 100/0 → valid after 1 edge, quotient 32767, div_by_zero=1. −5/0 → quotient −32768.
5. Backpressure: hold `ready_out`=0 for 10 cycles after `valid_out` → outputs stable and `ready_in`=0. Release → one handshake, then IDLE and `ready_in`=1 next cycle.
6. Reset mid-CALC: assert reset (low) 10 edges after accept → `valid_out` stays 0, all outputs 0. After deassertion a new 194/10 completes normally in 25 edges.

Source files
------------

// File: rtl/divide_iter.sv
// divide_iter: iterative signed fixed-point divider.
// Computes (dividend << QUANTIZED_BITS) / divisor with a restoring
// divider that retires one quotient bit per clock, then sign-corrects and
// saturates the result to DATA_WIDTH bits.
//
// Ports:
//   clock, reset        rising-edge clock, async active-low reset
//   valid_in/ready_in   operand handshake (ready only in IDLE)
//   dividend, divisor   signed Q-format operands
//   id_in / id_out      opaque tag carried with the operation
//   valid_out/ready_out result handshake, result held until accepted
//   quotient            signed, saturated quotient
//   remainder           signed remainder of the unsaturated division
//   div_by_zero         divisor was zero
//   overflow            quotient was clamped to the signed range
//
// state | meaning
// IDLE  | waiting for operands, ready_in high
// CALC  | one restoring step per edge, then a final sign/saturate edge
// DONE  | result registered and held until ready_out
module divide_iter #(
   parameter int DATA_WIDTH     = 16,
   parameter int QUANTIZED_BITS = 8,
   parameter int ID_WIDTH       = 4
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  valid_in,
   output logic                  ready_in,
   input  logic [DATA_WIDTH-1:0] dividend,
   input  logic [DATA_WIDTH-1:0] divisor,
   input  logic [ID_WIDTH-1:0]   id_in,
   output logic                  valid_out,
   input  logic                  ready_out,
   output logic [DATA_WIDTH-1:0] quotient,
   output logic [DATA_WIDTH-1:0] remainder,
   output logic                  div_by_zero,
   output logic                  overflow,
   output logic [ID_WIDTH-1:0]   id_out
);

   localparam int W  = DATA_WIDTH;
   localparam int NW = DATA_WIDTH + QUANTIZED_BITS;
   localparam int CW = $clog2(NW + 1);

   localparam logic [W-1:0]  ONE_W   = {{(W-1){1'b0}}, 1'b1};
   localparam logic [W-1:0]  SAT_MAX = {1'b0, {(W-1){1'b1}}};
   localparam logic [W-1:0]  SAT_MIN = {1'b1, {(W-1){1'b0}}};
   localparam logic [NW-1:0] POS_LIM = {{(NW-W+1){1'b0}}, {(W-1){1'b1}}};
   localparam logic [NW-1:0] NEG_LIM = POS_LIM + {{(NW-1){1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t          state_q;
   logic [CW-1:0]   cnt_q;
   logic [NW-1:0]   num_q;      // numerator bits shift out, quotient bits shift in
   logic [W:0]      rem_q;
   logic [W-1:0]    mag_b_q;
   logic            sign_a_q;
   logic            sign_b_q;
   logic [ID_WIDTH-1:0] id_q;

   logic            valid_q;
   logic [W-1:0]    quot_q;
   logic [W-1:0]    rem_out_q;
   logic            dz_out_q;
   logic            ovf_q;
   logic [ID_WIDTH-1:0] id_out_q;

   logic [W-1:0]    mag_a_in;
   logic [W-1:0]    mag_b_in;
   logic [NW-1:0]   num_load;
   logic [W:0]      rem_shift_d;
   logic            rem_ge;
   logic [W:0]      rem_d;
   logic [NW-1:0]   num_d;
   logic            q_neg;
   logic            ovf_d;
   logic [W-1:0]    quot_fin_d;
   logic [W-1:0]    rem_fin_d;

   always_comb begin
      // Two's-complement magnitude; the most negative value maps onto
      // 2^(W-1), which is still exact as an unsigned W-bit number.
      mag_a_in    = dividend[W-1] ? (~dividend + ONE_W) : dividend;
      mag_b_in    = divisor[W-1]  ? (~divisor  + ONE_W) : divisor;
      num_load    = NW'(mag_a_in) << QUANTIZED_BITS;

      rem_shift_d = {rem_q[W-1:0], num_q[NW-1]};
      rem_ge      = rem_shift_d >= {1'b0, mag_b_q};
      rem_d       = rem_ge ? (rem_shift_d - {1'b0, mag_b_q}) : rem_shift_d;
      num_d       = {num_q[NW-2:0], rem_ge};

      q_neg = sign_a_q ^ sign_b_q;
      if (q_neg) begin
         ovf_d      = num_q > NEG_LIM;
         quot_fin_d = ovf_d ? SAT_MIN : (~num_q[W-1:0] + ONE_W);
      end else begin
         ovf_d      = num_q > POS_LIM;
         quot_fin_d = ovf_d ? SAT_MAX : num_q[W-1:0];
      end
      // |remainder| < |divisor| <= 2^(W-1), so the low W bits hold it exactly.
      rem_fin_d = sign_a_q ? (~rem_q[W-1:0] + ONE_W) : rem_q[W-1:0];
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         num_q     <= '0;
         rem_q     <= '0;
         mag_b_q   <= '0;
         sign_a_q  <= 1'b0;
         sign_b_q  <= 1'b0;
         id_q      <= '0;
         valid_q   <= 1'b0;
         quot_q    <= '0;
         rem_out_q <= '0;
         dz_out_q  <= 1'b0;
         ovf_q     <= 1'b0;
         id_out_q  <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (valid_in) begin
                  sign_a_q <= dividend[W-1];
                  sign_b_q <= divisor[W-1];
                  id_q     <= id_in;
                  mag_b_q  <= mag_b_in;
                  num_q    <= num_load;
                  rem_q    <= '0;
                  cnt_q    <= CW'(NW);
                  state_q  <= (divisor == '0) ? S_DONE : S_CALC;
               end
            end
            S_CALC: begin
               if (cnt_q != '0) begin
                  rem_q <= rem_d;
                  num_q <= num_d;
                  cnt_q <= cnt_q - CW'(1);
               end else begin
                  quot_q    <= quot_fin_d;
                  rem_out_q <= rem_fin_d;
                  ovf_q     <= ovf_d;
                  dz_out_q  <= 1'b0;
                  id_out_q  <= id_q;
                  valid_q   <= 1'b1;
                  state_q   <= S_DONE;
               end
            end
            S_DONE: begin
               // DONE without a valid result only happens straight from a
               // zero-divisor accept: publish the fixed result one edge later.
               if (!valid_q) begin
                  quot_q    <= sign_a_q ? SAT_MIN : SAT_MAX;
                  rem_out_q <= '0;
                  dz_out_q  <= 1'b1;
                  ovf_q     <= 1'b0;
                  id_out_q  <= id_q;
                  valid_q   <= 1'b1;
               end else if (ready_out) begin
                  valid_q <= 1'b0;
                  state_q <= S_IDLE;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign ready_in    = (state_q == S_IDLE);
   assign valid_out   = valid_q;
   assign quotient    = quot_q;
   assign remainder   = rem_out_q;
   assign div_by_zero = dz_out_q;
   assign overflow    = ovf_q;
   assign id_out      = id_out_q;

endmodule

// File: tb/tb_divide_iter.sv
module tb_divide_iter;

   localparam int W   = 16;
   localparam int Q   = 8;
   localparam int IDW = 4;
   localparam longint MAXP = (longint'(1) <<< (W-1)) - 1;
   localparam longint MINN = -(longint'(1) <<< (W-1));

   logic           clock;
   logic           reset;
   logic           valid_in;
   logic           ready_in;
   logic [W-1:0]   dividend;
   logic [W-1:0]   divisor;
   logic [IDW-1:0] id_in;
   logic           valid_out;
   logic           ready_out;
   logic [W-1:0]   quotient;
   logic [W-1:0]   remainder;
   logic           div_by_zero;
   logic           overflow;
   logic [IDW-1:0] id_out;

   int checks = 0;
   int errors = 0;

   divide_iter #(
      .DATA_WIDTH(W),
      .QUANTIZED_BITS(Q),
      .ID_WIDTH(IDW)
   ) dut (
      .clock(clock),
      .reset(reset),
      .valid_in(valid_in),
      .ready_in(ready_in),
      .dividend(dividend),
      .divisor(divisor),
      .id_in(id_in),
      .valid_out(valid_out),
      .ready_out(ready_out),
      .quotient(quotient),
      .remainder(remainder),
      .div_by_zero(div_by_zero),
      .overflow(overflow),
      .id_out(id_out)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input longint obs, input longint exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Reference: plain integer arithmetic on the scaled numerator.
   // SV division truncates toward zero and % takes the dividend's sign.
   function automatic void ref_div(input longint a, input longint b,
                                   output longint q, output longint r,
                                   output longint dz, output longint ov);
      longint n;
      n = a * (longint'(1) <<< Q);
      if (b == 0) begin
         q  = (a >= 0) ? MAXP : MINN;
         r  = 0;
         dz = 1;
         ov = 0;
      end else begin
         q  = n / b;
         r  = n % b;
         dz = 0;
         ov = 0;
         if (q > MAXP) begin q = MAXP; ov = 1; end
         if (q < MINN) begin q = MINN; ov = 1; end
      end
   endfunction

   task automatic run_op(input longint a, input longint b,
                         input logic [IDW-1:0] id, input int stall);
      longint eq, er, edz, eov;
      int k;
      int lat;
      ref_div(a, b, eq, er, edz, eov);
      lat = (b == 0) ? 1 : (W + Q + 1);
      @(negedge clock);
      k = 0;
      while (!ready_in && k < 100) begin
         @(negedge clock);
         k++;
      end
      chk("ready_in_idle", ready_in, 1);
      valid_in = 1'b1;
      dividend = W'(a);
      divisor  = W'(b);
      id_in    = id;
      @(posedge clock);
      #1;
      valid_in = 1'b0;
      dividend = W'($urandom);
      divisor  = W'($urandom);
      id_in    = IDW'($urandom);
      @(negedge clock);
      chk("ready_in_busy", ready_in, 0);
      k = 0;
      while (!valid_out && k < 100) begin
         @(negedge clock);
         k++;
      end
      chk("latency", k, lat);
      chk("quotient", longint'($signed(quotient)), eq);
      chk("remainder", longint'($signed(remainder)), er);
      chk("div_by_zero", div_by_zero, edz);
      chk("overflow", overflow, eov);
      chk("id_out", id_out, id);
      for (int s = 0; s < stall; s++) begin
         @(negedge clock);
         chk("stall_quotient", longint'($signed(quotient)), eq);
         chk("stall_remainder", longint'($signed(remainder)), er);
         chk("stall_valid_ready", {valid_out, ready_in}, 2'b10);
      end
      ready_out = 1'b1;
      @(posedge clock);
      #1;
      ready_out = 1'b0;
      @(negedge clock);
      chk("post_valid_out", valid_out, 0);
      chk("post_ready_in", ready_in, 1);
   endtask

   initial begin
      longint ra, rb;
      reset     = 1'b0;
      valid_in  = 1'b0;
      ready_out = 1'b0;
      dividend  = '0;
      divisor   = '0;
      id_in     = '0;
      repeat (3) @(negedge clock);
      chk("rst_valid_out", valid_out, 0);
      chk("rst_quotient", quotient, 0);
      chk("rst_remainder", remainder, 0);
      chk("rst_flags", {div_by_zero, overflow}, 0);
      chk("rst_id_out", id_out, 0);
      reset = 1'b1;
      @(negedge clock);
      chk("rst_ready_in", ready_in, 1);

      // Known-answer anchor independent of the model.
      run_op(194, 10, 4'd3, 0);
      chk("kat_quotient", longint'($signed(quotient)), 4966);

      run_op(-194, 10, 4'd5, 0);
      run_op(194, -10, 4'd6, 0);
      run_op(-32768, -32768, 4'd7, 0);
      run_op(32767, 1, 4'd8, 0);
      run_op(-32768, 1, 4'd9, 0);
      run_op(100, 0, 4'd10, 0);
      run_op(-5, 0, 4'd11, 0);
      run_op(0, 0, 4'd12, 0);
      run_op(1, -32768, 4'd13, 0);
      run_op(32767, -32768, 4'd14, 0);
      run_op(-32768, 128, 4'd15, 0);
      run_op(-32768, 127, 4'd1, 0);

      // Backpressure: hold ready_out low for 10 cycles.
      run_op(1234, -77, 4'd2, 10);

      // Reset 10 edges into CALC abandons the operation.
      @(negedge clock);
      valid_in = 1'b1;
      dividend = W'(194);
      divisor  = W'(10);
      id_in    = 4'd3;
      @(posedge clock);
      #1;
      valid_in = 1'b0;
      repeat (10) @(posedge clock);
      #1;
      reset = 1'b0;
      #1;
      chk("midrst_valid_out", valid_out, 0);
      chk("midrst_quotient", quotient, 0);
      chk("midrst_remainder", remainder, 0);
      chk("midrst_flags", {div_by_zero, overflow}, 0);
      chk("midrst_id_out", id_out, 0);
      repeat (3) @(negedge clock);
      chk("midrst_hold_valid", valid_out, 0);
      reset = 1'b1;
      run_op(194, 10, 4'd3, 0);

      // Randomized operands against the arithmetic reference.
      for (int i = 0; i < 40; i++) begin
         ra = longint'($signed(W'($urandom)));
         case ($urandom_range(0, 3))
            0: rb = longint'($signed(W'($urandom)));
            1: rb = longint'($urandom_range(0, 40)) - 20;
            2: begin
               rb = longint'($signed(W'($urandom)));
               ra = longint'($urandom_range(0, 255)) - 128;
            end
            default: rb = longint'($signed(W'($urandom_range(0, 4095)))) - 2048;
         endcase
         run_op(ra, rb, IDW'($urandom), $urandom_range(0, 2));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
